load_store_unit: RTL

- Initiator side of the data-memory load/store interface. Accepts one load/store request at a time from the execute stage and drives a word-addressed memory port with byte enables.
- Splits misaligned accesses into two word transactions.
- Assembles and sign/zero-extends load data, then returns a single response to the pipeline.
- Byte order is big-endian: address offset 0 maps to data bits [31:24].

---
 rtl/load_store_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-memory load/store initiator: big-endian lanes, misaligned split into two words.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of splitting.
module load_store_unit #(
    parameter int              WIDTH      = 32,
    parameter logic [WIDTH-1:0] ADDR_LIMIT = 32'h1FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_mode,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t state, state_nx;

    logic             we_q;
    logic             err_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] word1_q;
    logic [WIDTH-1:0] rdata_q;

    function automatic logic [2:0] mode_size(input logic [2:0] mode);
        logic [2:0] s;
        unique case (mode)
            3'b001:          s = 3'd4;
            3'b010, 3'b100:  s = 3'd2;
            3'b011, 3'b101:  s = 3'd1;
            default:         s = 3'd0;
        endcase
        return s;
    endfunction

    logic [2:0]     req_size;
    logic [WIDTH:0] req_last;
    logic           req_misalign;
    logic           req_err;

    assign req_size = mode_size(req_mode);
    // one extra bit so a last-byte address past the top cannot wrap below the limit
    assign req_last = {1'b0, req_addr}
                    + {{(WIDTH-2){1'b0}}, req_size}
                    - {{WIDTH{1'b0}}, 1'b1};

`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] req_end;
    assign req_end = {1'b0, req_addr[1:0]} + req_size;
    assign req_misalign = (req_end > 3'd4)
                       || (req_size == 3'd4 && req_addr[1:0] != 2'b00)
                       || (req_size == 3'd2 && req_addr[0]);
`else
    assign req_misalign = 1'b0;
`endif

    assign req_err = (req_size == 3'd0)
                  || (req_last >= {1'b0, ADDR_LIMIT})
                  || req_misalign;

    logic [2:0]         size_q;
    logic [1:0]         o_q;
    logic [WIDTH-1:0]   st_just;
    logic [2*WIDTH-1:0] st_win;
    logic [3:0]         be_just;
    logic [7:0]         be_win;
    logic               split;

    assign size_q = mode_size(mode_q);
    assign o_q    = addr_q[1:0];

    // left-justify the value, then slide it across a two-word window by the offset
    always_comb begin
        st_just = '0;
        be_just = 4'b0000;
        unique case (size_q)
            3'd4: begin
                st_just = wdata_q;
                be_just = 4'b1111;
            end
            3'd2: begin
                st_just = {wdata_q[15:0], 16'h0000};
                be_just = 4'b1100;
            end
            3'd1: begin
                st_just = {wdata_q[7:0], 24'h000000};
                be_just = 4'b1000;
            end
            default: ;
        endcase
    end

    assign st_win = {st_just, {WIDTH{1'b0}}} >> {o_q, 3'b000};
    assign be_win = {be_just, 4'b0000} >> o_q;
    assign split  = |be_win[3:0];

    logic [55:0]      ld_win;
    logic [WIDTH-1:0] ld_top;
    logic [WIDTH-1:0] ld_val;
    logic             done_ack;

    // a split read never reaches lane 3 of the second word
    assign ld_win = (state == ACC2) ? {word1_q, mem_rdata[31:8]}
                                    : {mem_rdata, 24'h000000};

    always_comb begin
        ld_top = '0;
        unique case (o_q)
            2'd0: ld_top = ld_win[55:24];
            2'd1: ld_top = ld_win[47:16];
            2'd2: ld_top = ld_win[39:8];
            2'd3: ld_top = ld_win[31:0];
        endcase
    end

    always_comb begin
        ld_val = '0;
        unique case (mode_q)
            3'b001:  ld_val = ld_top;
            3'b010:  ld_val = {{16{ld_top[31]}}, ld_top[31:16]};
            3'b011:  ld_val = {{24{ld_top[31]}}, ld_top[31:24]};
            3'b100:  ld_val = {16'h0000, ld_top[31:16]};
            3'b101:  ld_val = {24'h000000, ld_top[31:24]};
            default: ld_val = '0;
        endcase
    end

    assign done_ack = mem_ack
                   && ((state == ACC1 && !split) || state == ACC2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = req_err ? RESP : ACC1;
                end
            end
            ACC1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
                mem_be    = be_win[7:4];
                mem_wdata = we_q ? st_win[2*WIDTH-1:WIDTH] : '0;
                if (mem_ack) begin
                    state_nx = split ? ACC2 : RESP;
                end
            end
            ACC2: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[WIDTH-1:2] + {{(WIDTH-3){1'b0}}, 1'b1}, 2'b00};
                mem_be    = be_win[3:0];
                mem_wdata = we_q ? st_win[WIDTH-1:0] : '0;
                if (mem_ack) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = rdata_q;
                state_nx  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            word1_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                err_q   <= req_err;
                mode_q  <= req_mode;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if (state == ACC1 && mem_ack) begin
                word1_q <= mem_rdata;
            end
            if (done_ack && !we_q) begin
                rdata_q <= ld_val;
            end
        end
    end

endmodule
